// File: rtl/control_hazard_pipeline_tracker.sv
// Three-stage destination-type tracker feeding the control hazard detector.
// Optional hazard stall counter enabled by defining TIA_HAZARD_STALL_COUNTER_EN.
module control_hazard_pipeline_tracker #(
  parameter int unsigned STALL_COUNT_WIDTH = 16,
  parameter int unsigned TIA_DT_WIDTH = 2,
  parameter logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_NULL = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [TIA_DT_WIDTH-1:0] issue_dt,
  output logic                    issue_ready,
  input  logic                    hazard,
  input  logic                    pipeline_stall,
  input  logic                    flush,
  output logic [TIA_DT_WIDTH-1:0] first_downstream_dt,
  output logic [TIA_DT_WIDTH-1:0] second_downstream_dt,
  output logic [TIA_DT_WIDTH-1:0] third_downstream_dt,
  output logic                    retire_valid,
`ifdef TIA_HAZARD_STALL_COUNTER_EN
  output logic [TIA_DT_WIDTH-1:0] retire_dt,
  output logic [STALL_COUNT_WIDTH-1:0] hazard_stall_count
`else
  output logic [TIA_DT_WIDTH-1:0] retire_dt
`endif
);

  typedef struct packed {
    logic                    valid;
    logic [TIA_DT_WIDTH-1:0] dt;
  } entry_t;

  // Index 0 is stage 1 (youngest), index 2 is stage 3 (oldest).
  entry_t stage_q [3];
  logic   fire;

  always_comb begin
    issue_ready = !hazard && !pipeline_stall && !flush;
    fire        = issue_valid && issue_ready;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int unsigned i = 0; i < 3; i++) begin
        stage_q[i] <= '0;
      end
    end else if (!pipeline_stall) begin
      stage_q[2] <= stage_q[1];
      stage_q[1] <= stage_q[0];
      stage_q[0] <= fire ? {1'b1, issue_dt} : '0;
    end
  end

  always_comb begin
    first_downstream_dt  = stage_q[0].valid ? stage_q[0].dt : TIA_DESTINATION_TYPE_NULL;
    second_downstream_dt = stage_q[1].valid ? stage_q[1].dt : TIA_DESTINATION_TYPE_NULL;
    third_downstream_dt  = stage_q[2].valid ? stage_q[2].dt : TIA_DESTINATION_TYPE_NULL;
    retire_valid         = stage_q[2].valid && !pipeline_stall && !flush;
    retire_dt            = retire_valid ? stage_q[2].dt : TIA_DESTINATION_TYPE_NULL;
  end

`ifdef TIA_HAZARD_STALL_COUNTER_EN
  logic [STALL_COUNT_WIDTH-1:0] count_q;

  // Saturating: holds at all-ones rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (issue_valid && hazard && !pipeline_stall && !flush && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign hazard_stall_count = count_q;
`endif

endmodule

// File: tb/tb_control_hazard_pipeline_tracker.sv
// Scoreboard bench: age-based reference model predicts outputs, monitor compares.
module tb_control_hazard_pipeline_tracker;
  localparam int SCW = 2;
  localparam logic [1:0] DT_NULL = 2'd0, DT_CHAN = 2'd1, DT_REG = 2'd2, DT_PRED = 2'd3;

  logic clock = 1'b0;
  logic reset, issue_valid, hazard, pipeline_stall, flush;
  logic [1:0] issue_dt;
  logic issue_ready, retire_valid;
  logic [1:0] first_downstream_dt, second_downstream_dt, third_downstream_dt, retire_dt;
`ifdef TIA_HAZARD_STALL_COUNTER_EN
  logic [SCW-1:0] hazard_stall_count;
`endif

  control_hazard_pipeline_tracker #(.STALL_COUNT_WIDTH(SCW)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_dt(issue_dt),
    .issue_ready(issue_ready), .hazard(hazard), .pipeline_stall(pipeline_stall),
    .flush(flush), .first_downstream_dt(first_downstream_dt),
    .second_downstream_dt(second_downstream_dt), .third_downstream_dt(third_downstream_dt),
    .retire_valid(retire_valid),
`ifdef TIA_HAZARD_STALL_COUNTER_EN
    .retire_dt(retire_dt), .hazard_stall_count(hazard_stall_count)
`else
    .retire_dt(retire_dt)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int failed = 0;

  // Model: each in-flight instruction carries its age in unstalled edges since firing.
  typedef struct { logic [1:0] dt; int age; } ent_t;
  ent_t m[$];
  int   mcount = 0;

  typedef struct {
    logic ir; logic [1:0] d1, d2, d3; logic rv; logic [1:0] rd; int cnt; bit chk;
  } exp_t;
  exp_t q[$];
  event ev;

  function automatic bit has_age(int k);
    foreach (m[i]) if (m[i].age == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] stage_dt(int k);
    foreach (m[i]) if (m[i].age == k) return m[i].dt;
    return DT_NULL;
  endfunction

  function automatic bit any_pred();
    foreach (m[i]) if (m[i].dt == DT_PRED) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] dt, input logic st, input logic fl,
                       input logic rs, input logic xh, input bit do_chk);
    exp_t e;
    ent_t nq[$];
    logic fire;
    @(negedge clock);
    issue_valid = v; issue_dt = dt; pipeline_stall = st; flush = fl; reset = rs;
    hazard = xh || any_pred();
    #1;
    e.ir  = !hazard && !st && !fl;
    e.d1  = stage_dt(1);
    e.d2  = stage_dt(2);
    e.d3  = stage_dt(3);
    e.rv  = has_age(3) && !st && !fl;
    e.rd  = e.rv ? stage_dt(3) : DT_NULL;
    e.cnt = mcount;
    e.chk = do_chk;
    q.push_back(e);
    ->ev;
    fire = v && e.ir;
    @(posedge clock);
    if (rs) begin
      m.delete();
      mcount = 0;
    end else begin
      if (v && hazard && !st && !fl && mcount < (1 << SCW) - 1) mcount++;
      if (fl) m.delete();
      else if (!st) begin
        foreach (m[i]) if (m[i].age < 3) nq.push_back('{m[i].dt, m[i].age + 1});
        if (fire) nq.push_back('{dt, 1});
        m = nq;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(ev);
      #1;
      e = q.pop_front();
      if (e.chk) begin
        chk("issue_ready", 32'(issue_ready), 32'(e.ir));
        chk("first_dt", 32'(first_downstream_dt), 32'(e.d1));
        chk("second_dt", 32'(second_downstream_dt), 32'(e.d2));
        chk("third_dt", 32'(third_downstream_dt), 32'(e.d3));
        chk("retire_valid", 32'(retire_valid), 32'(e.rv));
        chk("retire_dt", 32'(retire_dt), 32'(e.rd));
`ifdef TIA_HAZARD_STALL_COUNTER_EN
        chk("stall_count", 32'(hazard_stall_count), 32'(e.cnt));
`endif
      end
    end
  end

  initial begin : stim
    logic [1:0] rdt;
    int r;
    reset = 1'b1; issue_valid = 1'b0; issue_dt = DT_NULL; hazard = 1'b0;
    pipeline_stall = 1'b0; flush = 1'b0;
    drive(0, DT_NULL, 0, 0, 1, 0, 0);
    drive(0, DT_NULL, 0, 0, 1, 0, 1);
    // Predicate fire: blocked cycles 1-3, fires again cycle 4.
    drive(1, DT_PRED, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, DT_REG, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, DT_NULL, 0, 0, 0, 0, 1);
    // Back-to-back issues with mixed types to expose ordering.
    drive(1, DT_REG, 0, 0, 0, 0, 1);
    drive(1, DT_CHAN, 0, 0, 0, 0, 1);
    drive(1, DT_REG, 0, 0, 0, 0, 1);
    drive(1, DT_NULL, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, DT_NULL, 0, 0, 0, 0, 1);
    // Predicate in stage 2, then two stall cycles.
    drive(1, DT_PRED, 0, 0, 0, 0, 1);
    drive(1, DT_REG, 0, 0, 0, 0, 1);
    drive(1, DT_REG, 1, 0, 0, 0, 1);
    drive(1, DT_REG, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, DT_CHAN, 0, 0, 0, 0, 1);
    // Flush together with stall over three valid entries.
    drive(1, DT_REG, 0, 0, 0, 0, 1);
    drive(1, DT_CHAN, 0, 0, 0, 0, 1);
    drive(1, DT_REG, 0, 0, 0, 0, 1);
    drive(1, DT_CHAN, 1, 1, 0, 0, 1);
    drive(1, DT_REG, 0, 0, 0, 0, 1);
    drive(0, DT_NULL, 0, 0, 0, 0, 1);
    // Reset mid-stream with issue and flush asserted.
    drive(1, DT_PRED, 0, 0, 0, 0, 1);
    drive(1, DT_REG, 0, 0, 0, 1, 1);
    drive(1, DT_REG, 0, 1, 1, 0, 1);
    drive(0, DT_NULL, 0, 0, 0, 0, 1);
    // Saturation: five hazard-blocked issue attempts.
    for (int i = 0; i < 5; i++) drive(1, DT_REG, 0, 0, 0, 1, 1);
    drive(0, DT_NULL, 0, 0, 0, 0, 1);
    drive(0, DT_NULL, 0, 0, 1, 0, 1);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      rdt = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 99) < 70), rdt, ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 5), (r < 2), ($urandom_range(0, 99) < 10), 1);
    end
    drive(0, DT_NULL, 0, 0, 0, 0, 1);
    #20;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/control_hazard_pipeline_tracker.md
CONTROL_HAZARD_PIPELINE_TRACKER -- requirements
Module: control_hazard_pipeline_tracker

Interface
REQ-001 SHALL have parameter STALL_COUNT_WIDTH, default 16, width of the hazard stall counter (used only under REQ-030).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port issue_valid  input  1  trigger stage presents an instruction for issue.
REQ-005 SHALL have port issue_dt  input  TIA_DT_WIDTH  destination type of the presented instruction.
REQ-006 SHALL have port issue_ready  output  1  instruction is accepted this cycle.
REQ-007 SHALL have port hazard  input  1  combinational control-hazard flag from the three-stage control hazard detector.
REQ-008 SHALL have port pipeline_stall  input  1  freezes all three tracked stages.
REQ-009 SHALL have port flush  input  1  discards all in-flight entries.
REQ-010 SHALL have ports first_downstream_dt, second_downstream_dt, third_downstream_dt  output  TIA_DT_WIDTH each  destination types of stages 1/2/3, to the hazard detector.
REQ-011 SHALL have port retire_valid  output  1  stage-3 entry leaves the tracker this cycle.
REQ-012 SHALL have port retire_dt  output  TIA_DT_WIDTH  destination type of the retiring entry.

Function
REQ-013 SHALL hold three entries (stage 1 youngest, stage 3 oldest), each a valid bit plus TIA_DT_WIDTH dt.
REQ-014 SHALL drive each *_downstream_dt with the stage dt when valid, else TIA_DESTINATION_TYPE_NULL.
REQ-015 SHALL compute issue_ready = !hazard && !pipeline_stall && !flush, combinationally.
REQ-016 SHALL define fire = issue_valid && issue_ready; issue_valid SHALL not depend on issue_ready.
REQ-017 SHALL, on an edge with !flush && !pipeline_stall, shift: stage3<=stage2, stage2<=stage1, stage1<=(fire ? {1, issue_dt} : bubble).
REQ-018 SHALL, on an edge with pipeline_stall && !flush, hold all three entries unchanged.
REQ-019 SHALL, on an edge with flush, invalidate all three entries regardless of pipeline_stall; flush has priority over stall.
REQ-020 SHALL drive retire_valid = stage3.valid && !pipeline_stall && !flush; retire_dt = stage3 dt when retire_valid, else TIA_DESTINATION_TYPE_NULL.
REQ-021 SHALL have one-cycle latency from fire to the entry appearing on first_downstream_dt; an entry SHALL reach third_downstream_dt two unstalled edges later.
REQ-022 SHALL, with hazard driven from this block's outputs, block issue for exactly three unstalled cycles after a predicate-destination instruction fires; stall cycles extend the window one-for-one.
REQ-023 SHALL never drop or duplicate an entry except under flush or reset.

Reset
REQ-024 SHALL, on a clock edge with reset high, invalidate all three entries; reset has priority over flush and stall.
REQ-025 SHALL, in the cycle after reset, drive all *_downstream_dt and retire_dt to TIA_DESTINATION_TYPE_NULL and retire_valid to 0.
REQ-026 SHALL drive issue_ready purely from REQ-015 during reset; an instruction firing during reset SHALL be discarded.
REQ-027 SHALL clear the stall counter (REQ-030) on reset.

Configuration
REQ-028 SHALL support macro TIA_HAZARD_STALL_COUNTER_EN.
REQ-029 SHALL, without the macro, have no counter state and no hazard_stall_count port.
REQ-030 SHALL, with the macro, add output hazard_stall_count [STALL_COUNT_WIDTH] that increments by 1 on each edge where issue_valid && hazard && !pipeline_stall && !flush && !reset, saturates at all-ones, and resets to 0.

Verification
REQ-031 SHALL cover: fire predicate dt at cycle 0, no stalls -> first/second/third_downstream_dt = PREDICATE in cycles 1/2/3, retire_valid=1 in cycle 3, issue_ready low cycles 1-3, high cycle 4.
REQ-032 SHALL cover: back-to-back register-dt issues on 4 consecutive cycles -> issue_ready=1 throughout, retire_valid=1 cycles 3-6 with matching dt order.
REQ-033 SHALL cover: predicate dt in stage 2 plus pipeline_stall for 2 cycles -> all entries frozen, retire_valid=0, and issue blocked 2 extra cycles (5 total).
REQ-034 SHALL cover: flush and pipeline_stall together with 3 valid entries -> all outputs NULL next cycle, no retire, issue_ready=1 the following cycle.
REQ-035 SHALL cover: reset asserted mid-stream with issue_valid=1 and flush=1 -> all stages NULL after the edge, counter = 0 (macro build).
REQ-036 SHALL cover (macro build, STALL_COUNT_WIDTH=2): 5 hazard-blocked issue_valid cycles -> hazard_stall_count reads 1,2,3,3,3.
